// File: rtl/cga_alu_pkg.sv
// Shared CGA/ALU types and defaults: DBR load sequencer state encoding and
// parameter defaults used by the DBR read-cycle controller.
package cga_alu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        REL  = 3'd4
    } dbr_ld_state_t;

    localparam int unsigned DBR_TOUT_DEFAULT = 255;
    localparam int unsigned DBR_SYNC_DEFAULT = 2;

endpackage

// File: rtl/cga_sync_n.sv
// N-stage flip-flop synchroniser for active-low asynchronous handshake inputs;
// resets to 1 so an inactive (high) line is assumed until sampled.
module cga_sync_n #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            chain <= '1;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cga_alu_dbr_load_ctl.sv
// Read-cycle sequencer upstream of DBR: issues MREQN, waits for MRDYN, strobes
// LDDBRN low for one ALUCLK, and reports BUSY/DVALID plus a sticky TOUT.
module cga_alu_dbr_load_ctl
    import cga_alu_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DBR_SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = DBR_TOUT_DEFAULT,
    localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic ALUCLK,
    input  logic RESETN,
    input  logic RDREQ,
    input  logic LDCD,
    input  logic MRDYN,
    input  logic CLRTO,
    output logic MREQN,
    output logic LDDBRN,
    output logic BUSY,
    output logic DVALID,
    output logic TOUT
);

    dbr_ld_state_t    state;
    logic [CNT_W-1:0] waitCnt;
    logic             mrdySync;
    logic             armed;
    logic             loadQ;

    cga_sync_n #(.STAGES(SYNC_STAGES)) uMrdySync (
        .clk  (ALUCLK),
        .rstN (RESETN),
        .d    (MRDYN),
        .q    (mrdySync)
    );

    // Both terms are flop outputs or a clean microcode strobe: no decode glitches.
    assign LDDBRN = ~(loadQ | LDCD);

    always_ff @(posedge ALUCLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            waitCnt <= '0;
            armed   <= 1'b0;
            loadQ   <= 1'b0;
            MREQN   <= 1'b1;
            BUSY    <= 1'b0;
            DVALID  <= 1'b0;
            TOUT    <= 1'b0;
        end else begin
            loadQ <= 1'b0;
            if (CLRTO) TOUT <= 1'b0;

            // A ready only counts once MRDYN has been seen high after the
            // request, so a low level left over from before is never taken.
            case (state)
                IDLE: begin
                    armed <= 1'b0;
                    if (RDREQ) begin
                        state  <= REQ;
                        MREQN  <= 1'b0;
                        BUSY   <= 1'b1;
                        DVALID <= 1'b0;
                    end
                end
                REQ: begin
                    waitCnt <= '0;
                    state   <= WAIT;
                    if (mrdySync) armed <= 1'b1;
                end
                WAIT: begin
                    if (mrdySync) armed <= 1'b1;
                    if (!mrdySync && armed) begin
                        state <= LOAD;
                        MREQN <= 1'b1;
                        loadQ <= 1'b1;
                    end else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state  <= IDLE;
                        MREQN  <= 1'b1;
                        BUSY   <= 1'b0;
                        DVALID <= 1'b0;
                        TOUT   <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                LOAD: begin
                    DVALID <= 1'b1;
                    state  <= REL;
                end
                REL: begin
                    if (mrdySync) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    MREQN <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase

            if (LDCD) DVALID <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cga_alu_dbr_load_ctl.sv
// Self-checking bench for cga_alu_dbr_load_ctl: directed cases followed by
// randomized read transactions checked against a per-cycle timing model.
module tb_cga_alu_dbr_load_ctl;

    localparam int S     = 2;
    localparam int T     = 4;
    localparam int NEVER = 1000;

    logic ALUCLK = 1'b0;
    logic RESETN = 1'b0;
    logic RDREQ  = 1'b0;
    logic LDCD   = 1'b0;
    logic MRDYN  = 1'b1;
    logic CLRTO  = 1'b0;
    logic MREQN, LDDBRN, BUSY, DVALID, TOUT;

    logic [15:0] cd  = 16'hA5C3;
    logic [15:0] dbr = 16'h0000;

    int   checks = 0;
    int   passes = 0;
    logic expDvalid = 1'b0;
    logic expTout   = 1'b0;
    bit   rdreqV[64];
    bit   ldcdV[64];
    bit   clrtoV[64];

    cga_alu_dbr_load_ctl #(
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .ALUCLK (ALUCLK),
        .RESETN (RESETN),
        .RDREQ  (RDREQ),
        .LDCD   (LDCD),
        .MRDYN  (MRDYN),
        .CLRTO  (CLRTO),
        .MREQN  (MREQN),
        .LDDBRN (LDDBRN),
        .BUSY   (BUSY),
        .DVALID (DVALID),
        .TOUT   (TOUT)
    );

    always #5 ALUCLK = ~ALUCLK;

    // DBR register downstream of the sequencer.
    always @(posedge ALUCLK) if (!LDDBRN) dbr <= cd;

    task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic clearVecs();
        foreach (rdreqV[i]) begin
            rdreqV[i] = 1'b0;
            ldcdV[i]  = 1'b0;
            clrtoV[i] = 1'b0;
        end
    endtask

    task automatic idleCycle(input bit ldcd, input bit clrto, input bit mrdyn);
        RDREQ = 1'b0;
        LDCD  = ldcd;
        CLRTO = clrto;
        MRDYN = mrdyn;
        @(negedge ALUCLK);
        chk("idle", 0, 16'({MREQN, LDDBRN, BUSY, DVALID, TOUT}),
            16'({1'b1, !ldcd, 1'b0, expDvalid, expTout}));
        if (ldcd) expDvalid = 1'b1;
        if (clrto) expTout = 1'b0;
        @(posedge ALUCLK); #1;
    endtask

    // One read request at relative cycle 0. MRDYN falls at cycle f and rises at r;
    // with stale set it is also low before the request and rises at cycle 1.
    task automatic runTxn(input int f, input int r, input bit stale);
        bit   load;
        int   L, E;
        logic mreqE, busyE, lddE;
        bit   ld;
        load = (f + S <= T + 1);
        L    = f + S + 1;
        E    = load ? (((L + 1 > r + S) ? L + 1 : r + S) + 1) : T + 2;
        for (int c = 0; c <= E; c++) begin
            ld    = ldcdV[c] && (c > 0) && !(!load && c == T + 1);
            RDREQ = (c == 0) || (c < E && rdreqV[c]);
            LDCD  = ld;
            CLRTO = clrtoV[c];
            MRDYN = !((stale && c < 1) || (c >= f && c < r));
            @(negedge ALUCLK);
            mreqE = !(c >= 1 && c < (load ? L : T + 2));
            busyE = (c >= 1 && c < E);
            lddE  = !((load && c == L) || ld);
            chk("txn", c, 16'({MREQN, LDDBRN, BUSY, DVALID, TOUT}),
                16'({mreqE, lddE, busyE, expDvalid, expTout}));
            if (ld) expDvalid = 1'b1;
            else if (c == 0) expDvalid = 1'b0;
            else if (load && c == L) expDvalid = 1'b1;
            else if (!load && c == T + 1) expDvalid = 1'b0;
            if (!load && c == T + 1) expTout = 1'b1;
            else if (clrtoV[c]) expTout = 1'b0;
            @(posedge ALUCLK); #1;
        end
    endtask

    initial begin
        clearVecs();
        // Reset
        repeat (2) @(posedge ALUCLK);
        @(negedge ALUCLK);
        chk("inReset", 0, 16'({MREQN, LDDBRN, BUSY, DVALID, TOUT}), 16'h0018);
        @(posedge ALUCLK); #1;
        RESETN = 1'b1;
        repeat (3) idleCycle(0, 0, 1);

        // Normal read, ready on the last WAIT cycle
        runTxn(3, 8, 0);
        chk("dbr", 0, dbr, 16'hA5C3);
        repeat (3) idleCycle(0, 0, 1);

        // Timeout, then CLRTO
        runTxn(NEVER, NEVER + 1, 0);
        idleCycle(0, 0, 1);
        idleCycle(0, 1, 1);
        idleCycle(0, 0, 1);

        // Ready one cycle too late -> timeout
        runTxn(4, 7, 0);
        repeat (3) idleCycle(0, 0, 1);

        // CLRTO on the timeout cycle: set wins
        clrtoV[T + 1] = 1'b1;
        runTxn(NEVER, NEVER + 1, 0);
        clearVecs();
        idleCycle(0, 1, 1);
        idleCycle(0, 0, 1);

        // LDCD alone in IDLE
        idleCycle(1, 0, 1);
        idleCycle(0, 0, 1);
        idleCycle(0, 0, 1);

        // LDCD coincident with LOAD, then RDREQ during WAIT
        ldcdV[6] = 1'b1;
        runTxn(3, 8, 0);
        clearVecs();
        repeat (3) idleCycle(0, 0, 1);
        rdreqV[3] = 1'b1;
        runTxn(3, 9, 0);
        clearVecs();
        repeat (3) idleCycle(0, 0, 1);

        // Stale ready before the request
        repeat (3) idleCycle(0, 0, 0);
        runTxn(NEVER, NEVER + 1, 1);
        repeat (3) idleCycle(0, 1, 0);
        runTxn(2, 6, 1);
        repeat (3) idleCycle(0, 1, 1);

        // Reset asserted mid-WAIT with a ready already in flight
        RDREQ = 1'b1; MRDYN = 1'b1;
        @(posedge ALUCLK); #1;
        RDREQ = 1'b0;
        @(posedge ALUCLK); #1;
        MRDYN = 1'b0;
        @(posedge ALUCLK); #1;
        @(negedge ALUCLK);
        chk("rstPreWait", 0, 16'({MREQN, BUSY}), 16'h0001);
        #2 RESETN = 1'b0;
        #1 chk("rstAsync", 0, 16'({MREQN, LDDBRN, BUSY, DVALID, TOUT}), 16'h0018);
        for (int k = 0; k < 3; k++) begin
            @(negedge ALUCLK);
            chk("rstHold", k, 16'({MREQN, LDDBRN, BUSY, DVALID, TOUT}), 16'h0018);
        end
        @(posedge ALUCLK); #1;
        RESETN = 1'b1;
        expDvalid = 1'b0;
        expTout   = 1'b0;
        repeat (4) idleCycle(0, 0, 1);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int f, r, nIdle;
            bit stale;
            stale = ($urandom_range(0, 3) == 0);
            f = int'($urandom_range(1, 5));
            if (f == 5) f = NEVER;
            if (stale && f < 2) f = 2;
            r = f + 1 + int'($urandom_range(0, 5));
            nIdle = int'($urandom_range(3, 5));
            for (int k = 0; k < nIdle; k++)
                idleCycle($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, !stale);
            for (int c = 0; c < 64; c++) begin
                rdreqV[c] = (c >= 1) && ($urandom_range(0, 5) == 0);
                ldcdV[c]  = (c >= 1) && ($urandom_range(0, 7) == 0);
                clrtoV[c] = ($urandom_range(0, 4) == 0);
            end
            runTxn(f, r, stale);
        end
        clearVecs();
        repeat (3) idleCycle(0, 0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cga_alu_dbr_load_ctl.md
Name: cga_alu_dbr_load_ctl

Overview:
- Read-cycle sequencer directly upstream of the DBR register in /CGA/ALU.
- Accepts a microcode read request, handshakes with memory over MREQN/MRDYN, and pulses LDDBRN low for exactly one ALUCLK to capture CD_15_0 into DBR.
- Provides busy/valid status to the microsequencer and a sticky timeout flag for missing memory responses.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages on MRDYN; legal values 1..3.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort; legal range 1..1023.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter; derived, never overridden.

Ports:
- ALUCLK  in  1  ALU clock; all state changes on the rising edge.
- RESETN  in  1  asynchronous active-low reset.
- RDREQ   in  1  microcode read request, sampled high for one cycle.
- LDCD    in  1  microcode direct load of DBR from CD, bypassing the handshake.
- MRDYN   in  1  memory data ready, active low, asynchronous to ALUCLK.
- CLRTO   in  1  clears TOUT.
- MREQN   out 1  memory read request, active low.
- LDDBRN  out 1  DBR load enable, active low, to DBR.
- BUSY    out 1  high whenever the FSM is not in IDLE.
- DVALID  out 1  DBR holds data from the last completed read.
- TOUT    out 1  sticky timeout flag.

Behaviour:
- Reset (async, RESETN low): FSM=IDLE, counter=0, synchroniser chain=1.
  - Outputs: MREQN=1, LDDBRN=1, BUSY=0, DVALID=0, TOUT=0.
  - Reset asserted mid-cycle aborts immediately and asserts no load.
- FSM states: IDLE, REQ, WAIT, LOAD, REL.
- IDLE:
  - RDREQ=1 -> REQ.
  - RDREQ=1 while BUSY is ignored; no queueing.
- REQ:
  - MREQN driven 0 from this state through WAIT.
  - Counter cleared; -> WAIT next cycle.
- WAIT:
  - Counter increments each cycle.
  - Synchronised MRDYN=0 -> LOAD.
  - Counter reaching TIMEOUT_CYCLES with no ready -> IDLE, TOUT=1, MREQN=1, DVALID=0, no load.
  - Ready and timeout in the same cycle: ready wins.
- LOAD:
  - LDDBRN=0 for exactly one cycle; MREQN=1.
  - DVALID=1 from the next cycle onward.
  - -> REL.
- REL:
  - Waits for synchronised MRDYN=1, then -> IDLE.
  - No timeout applies in this state.
- Latency: RDREQ at cycle 0 gives MREQN low at cycle 1. LDDBRN low occurs SYNC_STAGES+1 cycles after MRDYN falls, provided MRDYN falls while MREQN is low.
- LDCD:
  - Pulls LDDBRN low in the same cycle, combinationally ORed with the FSM load.
  - Sets DVALID=1 in any state.
  - Does not change FSM state.
  - LDCD coinciding with LOAD gives a single-cycle low pulse.
- DVALID cleared when RDREQ is accepted in IDLE; set again on load.
- TOUT:
  - Sticky until CLRTO=1.
  - CLRTO and a new timeout in the same cycle: TOUT stays 1 (set wins).
- MRDYN=0 while IDLE or REQ is ignored. A stale low ready before the request does not cause a load; WAIT acts only on a ready seen while in WAIT.
- All outputs are registered except LDDBRN. LDDBRN is the OR of registered LOAD and LDCD, so it is glitch-free relative to ALUCLK.

Decomposition:
- Shared package cga_alu_pkg:
  - State enum dbr_ld_state_t (IDLE, REQ, WAIT, LOAD, REL; 3-bit encoding).
  - Constants DBR_TOUT_DEFAULT=255 and DBR_SYNC_DEFAULT=2.
- Sub-module cga_sync_n: parameterised N-stage synchroniser with reset value 1, used for MRDYN. Reusable by other CGA handshake inputs.

Test Plan:
- Reset: RESETN low then high -> MREQN=1, LDDBRN=1, BUSY=0, DVALID=0, TOUT=0. Repeat with RESETN pulsed low during WAIT -> MREQN returns to 1 asynchronously and LDDBRN never pulses.
- Normal read, SYNC_STAGES=2: RDREQ at cycle 0, MRDYN low from cycle 3 -> MREQN low cycles 1–5, LDDBRN low in cycle 6 only, DBR=0xA5C3 when CD=0xA5C3. MRDYN high at cycle 8 -> BUSY=0 by cycle 11, DVALID=1.
- Timeout, TIMEOUT_CYCLES=4: RDREQ with MRDYN held high -> TOUT=1 after 4 WAIT cycles, no LDDBRN pulse, DVALID=0, BUSY=0. CLRTO=1 -> TOUT=0 next cycle.
- Simultaneous events: ready arriving on the last WAIT cycle -> load, TOUT stays 0. CLRTO asserted on a timeout cycle -> TOUT=1.
- LDCD: LDCD alone in IDLE -> one-cycle LDDBRN low, DVALID=1, BUSY=0. LDCD coincident with LOAD -> a single one-cycle low pulse.
- Ignored inputs: RDREQ during WAIT -> no second MREQN cycle. MRDYN low before RDREQ, then deasserted -> no load until a fresh ready in WAIT.
